// File: rtl/bbpd_vote_detector_pkg.sv
// Shared definitions for the bang-bang phase detector / vote decimator.
// Holds the decision encoding, the FSM state type and the vote_sum width helper.
package bbpd_vote_detector_pkg;

  // Decision encoding on master_out
  localparam logic DEC_UP = 1'b0;  // +1: advance / speed up
  localparam logic DEC_DN = 1'b1;  // -1: retard

  // Single Alexander votes, 2-bit signed
  localparam logic signed [1:0] VOTE_ZERO = 2'sb00;
  localparam logic signed [1:0] VOTE_PLUS = 2'sb01;
  localparam logic signed [1:0] VOTE_MINUS = 2'sb11;

  typedef enum logic {
    PRIME,
    ACCUM
  } state_t;

  // Width of the vote_sum port: clog2(WINDOW)+1
  function automatic int unsigned vote_width(input int unsigned window);
    return $clog2(window) + 1;
  endfunction

endpackage

// File: rtl/bbpd_vote_detector_if.sv
// Sampler-side and decision-side signals of the phase detector.
//   samp_valid/data_samp/edge_samp : sample pair from the recovered-clock samplers
//   hold                           : synchronous flush request
//   master_out/master_valid        : decision strobe towards the loop filter
//   vote_sum                       : signed sum of the last closed window (debug)
//   lock                           : phase error inside deadband
// Modport slave is the detector, modport master is its environment.
interface bbpd_vote_detector_if
  import bbpd_vote_detector_pkg::*;
#(
  parameter int unsigned WINDOW = 8
);

  localparam int unsigned VW = vote_width(WINDOW);

  logic                 samp_valid;
  logic                 data_samp;
  logic                 edge_samp;
  logic                 hold;
  logic                 master_out;
  logic                 master_valid;
  logic signed [VW-1:0] vote_sum;
  logic                 lock;

  modport slave (
    input  samp_valid, data_samp, edge_samp, hold,
    output master_out, master_valid, vote_sum, lock
  );

  modport master (
    output samp_valid, data_samp, edge_samp, hold,
    input  master_out, master_valid, vote_sum, lock
  );

endinterface

// File: rtl/bbpd_vote_detector_core.sv
// bbpd_core: combinational Alexander vote.
//   data_samp : current bit-centre sample
//   edge_samp : boundary sample between data_prev and data_samp
//   data_prev : previous bit-centre sample
//   vote      : signed vote, +1 clock late, -1 clock early, 0 no transition
module bbpd_core
  import bbpd_vote_detector_pkg::*;
(
  input  logic              data_samp,
  input  logic              edge_samp,
  input  logic              data_prev,
  output logic signed [1:0] vote
);

  always_comb begin
    vote = VOTE_ZERO;
    if (data_samp != data_prev) begin
      // With a transition the edge sample equals exactly one of the two bits
      vote = (edge_samp == data_samp) ? VOTE_PLUS : VOTE_MINUS;
    end
  end

endmodule

// File: rtl/bbpd_vote_detector.sv
// Bang-bang phase detector with vote decimation and lock detection.
// Accumulates Alexander votes over WINDOW valid sample pairs and emits one
// signed decision per window when |sum| >= THRESH; counts consecutive
// deadband windows to raise lock.
//   clk  : system clock
//   rstn : asynchronous active-low reset
//   bus  : sampler inputs, hold, decision outputs (see bbpd_vote_detector_if)
module bbpd_vote_detector
  import bbpd_vote_detector_pkg::*;
#(
  parameter int unsigned WINDOW   = 8,
  parameter int unsigned THRESH   = 2,
  parameter int unsigned LOCK_CNT = 4
) (
  input  logic                 clk,
  input  logic                 rstn,
  bbpd_vote_detector_if.slave  bus
);

  localparam int unsigned VW = vote_width(WINDOW);
  localparam int unsigned CW = $clog2(WINDOW);
  // One bit wider than vote_sum: a full window reaches +WINDOW, which the
  // VW-bit port cannot represent, so decisions are taken on the wide sum.
  localparam int unsigned SW = VW + 1;

  localparam logic signed [SW-1:0] THR      = SW'(THRESH);
  localparam logic        [CW-1:0] LAST_IDX = CW'(WINDOW - 1);
  localparam logic        [7:0]    LOCK_MAX = 8'(LOCK_CNT);

  state_t state, state_nxt;

  logic signed [SW-1:0] acc;
  logic        [CW-1:0] win_cnt;
  logic        [7:0]    lock_cnt;
  logic                 data_prev;

  logic                 master_out_q;
  logic                 master_valid_q;
  logic signed [VW-1:0] vote_sum_q;
  logic                 lock_q;

  logic signed [1:0]    vote;
  logic signed [SW-1:0] sum;
  logic                 take;
  logic                 close;
  logic                 emit_up;
  logic                 emit_dn;
  logic        [7:0]    lock_cnt_inc;

  bbpd_core u_core (
    .data_samp (bus.data_samp),
    .edge_samp (bus.edge_samp),
    .data_prev (data_prev),
    .vote      (vote)
  );

  always_comb begin
    take         = bus.samp_valid && !bus.hold;
    sum          = acc + {{(SW-2){vote[1]}}, vote};
    close        = take && (state == ACCUM) && (win_cnt == LAST_IDX);
    emit_up      = (sum >= THR);
    emit_dn      = (sum <= -THR);
    lock_cnt_inc = (lock_cnt == LOCK_MAX) ? LOCK_MAX : lock_cnt + 8'd1;
  end

  always_comb begin
    state_nxt = state;
    if (bus.hold) begin
      state_nxt = PRIME;
    end else if (bus.samp_valid && state == PRIME) begin
      state_nxt = ACCUM;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= PRIME;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc            <= '0;
      win_cnt        <= '0;
      lock_cnt       <= '0;
      data_prev      <= 1'b0;
      master_out_q   <= DEC_UP;
      master_valid_q <= 1'b0;
      vote_sum_q     <= '0;
      lock_q         <= 1'b0;
    end else begin
      master_valid_q <= 1'b0;
      if (take) begin
        data_prev <= bus.data_samp;
      end
      if (bus.hold) begin
        acc      <= '0;
        win_cnt  <= '0;
        lock_cnt <= '0;
        lock_q   <= 1'b0;
      end else if (close) begin
        acc        <= '0;
        win_cnt    <= '0;
        vote_sum_q <= sum[VW-1:0];
        if (emit_up || emit_dn) begin
          master_out_q   <= emit_up ? DEC_UP : DEC_DN;
          master_valid_q <= 1'b1;
          lock_cnt       <= '0;
          lock_q         <= 1'b0;
        end else begin
          lock_cnt <= lock_cnt_inc;
          lock_q   <= (lock_cnt_inc == LOCK_MAX);
        end
      end else if (take && state == ACCUM) begin
        acc     <= sum;
        win_cnt <= win_cnt + CW'(1);
      end
    end
  end

  assign bus.master_out   = master_out_q;
  assign bus.master_valid = master_valid_q;
  assign bus.vote_sum     = vote_sum_q;
  assign bus.lock         = lock_q;

endmodule

// File: tb/tb_bbpd_vote_detector.sv
// Self-checking bench for bbpd_vote_detector: directed windows, gapped
// windows, hold and mid-window reset, then randomized traffic, all compared
// cycle by cycle against a list-based window model.
module tb_bbpd_vote_detector;
  import bbpd_vote_detector_pkg::*;

  localparam int W  = 8;
  localparam int T  = 2;
  localparam int L  = 4;
  localparam int VW = vote_width(W);

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  bbpd_vote_detector_if #(.WINDOW(W)) bus ();

  bbpd_vote_detector #(
    .WINDOW   (W),
    .THRESH   (T),
    .LOCK_CNT (L)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.slave)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: a window is just the list of votes since priming
  bit m_primed;
  bit m_prev;
  int m_votes[$];
  int m_streak;
  bit m_mo, m_mv, m_lock;
  int m_vsum;

  bit cur;  // last data level presented with samp_valid

  task automatic check_eq(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_primed = 0;
    m_prev   = 0;
    m_votes.delete();
    m_streak = 0;
    m_mo     = 0;
    m_mv     = 0;
    m_lock   = 0;
    m_vsum   = 0;
  endfunction

  function automatic void model_step(input bit v, input bit d, input bit e, input bit h);
    int vote;
    int s;
    m_mv = 0;
    if (h) begin
      m_primed = 0;
      m_votes.delete();
      m_streak = 0;
      m_lock   = 0;
    end else if (v) begin
      if (!m_primed) begin
        m_primed = 1;
      end else begin
        if (d == m_prev)      vote = 0;
        else if (e == d)      vote = 1;
        else                  vote = -1;
        m_votes.push_back(vote);
        if (m_votes.size() == W) begin
          s = 0;
          foreach (m_votes[i]) s += m_votes[i];
          m_vsum = s;
          if (s >= T) begin
            m_mo = 0; m_mv = 1; m_streak = 0;
          end else if (s <= -T) begin
            m_mo = 1; m_mv = 1; m_streak = 0;
          end else begin
            m_streak = (m_streak + 1 > L) ? L : m_streak + 1;
          end
          m_lock = (m_streak == L);
          m_votes.delete();
        end
      end
      m_prev = d;
    end
  endfunction

  task automatic check_outputs();
    check_eq("master_valid", int'(bus.master_valid), int'(m_mv));
    check_eq("master_out", int'(bus.master_out), int'(m_mo));
    check_eq("lock", int'(bus.lock), int'(m_lock));
    check_eq("vote_sum", int'($unsigned(bus.vote_sum)), m_vsum & ((1 << VW) - 1));
  endtask

  // One clock: drive at negedge, model at posedge, compare at next negedge
  task automatic cyc(input bit v, input bit d, input bit e, input bit h);
    bus.samp_valid = v;
    bus.data_samp  = d;
    bus.edge_samp  = e;
    bus.hold       = h;
    @(posedge clk);
    model_step(v, d, e, h);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'($urandom), 1'($urandom), 1'b0);
  endtask

  task automatic do_hold();
    cyc(1'b0, 1'($urandom), 1'($urandom), 1'b1);
  endtask

  // Valid sample producing vote v relative to the previous valid data level
  task automatic send(input int v, input int gmin, input int gmax);
    bit d, e;
    if (gmax > 0) idle($urandom_range(gmax, gmin));
    if (v == 0) begin
      d = cur; e = 1'($urandom);
    end else begin
      d = ~cur;
      e = (v > 0) ? d : cur;
    end
    cyc(1'b1, d, e, 1'b0);
    cur = d;
  endtask

  task automatic send_n(input int v, input int n);
    for (int i = 0; i < n; i++) send(v, 0, 0);
  endtask

  initial begin
    #400_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pat[8];
    model_reset();
    cur            = 0;
    rstn           = 1'b0;
    bus.samp_valid = 1'b0;
    bus.data_samp  = 1'b0;
    bus.edge_samp  = 1'b0;
    bus.hold       = 1'b0;
    repeat (2) @(negedge clk);
    check_outputs();
    rstn = 1'b1;

    // All late, then all early
    send(0, 0, 0);
    send_n(1, W);
    check_eq("t1_decision_up", int'(bus.master_out), int'(DEC_UP));
    send_n(-1, W);
    check_eq("t2_decision_dn", int'(bus.master_out), int'(DEC_DN));

    // Sum exactly THRESH, then a sum of +1 (deadband)
    pat = '{1, -1, 1, 0, 0, 0, 0, 1};
    foreach (pat[i]) send(pat[i], 0, 0);
    pat = '{1, 0, 0, 0, 0, 0, 0, 0};
    foreach (pat[i]) send(pat[i], 0, 0);

    // Four deadband windows raise lock, an emitting window drops it
    send_n(0, 3 * W);
    check_eq("t4_lock_rise", int'(bus.lock), 1);
    send_n(1, W);
    check_eq("t4_lock_fall", int'(bus.lock), 0);

    // Gapped window
    for (int i = 0; i < W; i++) send(-1, 1, 5);

    // hold mid-window, re-prime, full window of -1
    send_n(1, 5);
    do_hold();
    send(0, 0, 0);
    send_n(-1, W);

    // Async reset mid-window
    send_n(1, 3);
    rstn = 1'b0;
    #1;
    model_reset();
    check_outputs();
    for (int i = 0; i < 3; i++) begin
      bus.samp_valid = 1'($urandom);
      bus.data_samp  = 1'($urandom);
      @(negedge clk);
      check_outputs();
    end
    rstn = 1'b1;
    idle(2);
    send_n(1, W - 1);
    check_eq("t6_no_partial", int'(bus.master_valid), 0);
    send_n(1, 2);

    // Randomized traffic with occasional holds
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(39, 0) == 0) do_hold();
      send(int'($urandom_range(2, 0)) - 1, 0, ($urandom_range(3, 0) == 0) ? 3 : 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
